// File: rtl/sub_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
//   state_t   : controller state encoding (IDLE, RUN, DONE)
//   cnt_width : digit counter width for a given digit count (minimum 1 bit)
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned ndig);
    return (ndig <= 32'd1) ? 32'd1 : 32'($clog2(ndig));
  endfunction

endpackage

// File: rtl/sub_digit.sv
// Combinational DIGIT-bit ripple borrow subtractor: {bout, diff} = a - b - bin.
//   a, b  : DIGIT-bit operands
//   bin   : borrow-in
//   diff  : DIGIT-bit difference
//   bout  : borrow-out of the most significant bit
module sub_digit #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] diff,
  output logic             bout
);

  logic [DIGIT:0] brw;

  // Bit-level ripple borrow chain, LSB first.
  always_comb begin
    brw    = '0;
    diff   = '0;
    brw[0] = bin;
    for (int i = 0; i < int'(DIGIT); i++) begin
      diff[i]  = a[i] ^ b[i] ^ brw[i];
      brw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
    end
  end

  assign bout = brw[DIGIT];

endmodule

// File: rtl/digit_serial_subtractor.sv
// Multi-cycle unsigned subtractor: diff = a - b - bin (mod 2^WIDTH), DIGIT bits
// per clock, LSB digit first, borrow carried between cycles in a register.
// Valid/ready handshake on both sides; all outputs are registered.
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready : operand handshake (a, b, bin sampled on acceptance)
//   out_valid/out_ready : result handshake (diff, bout held stable in DONE)
// Build option: define SUB_SATURATE_EN to clamp diff to 0 whenever bout = 1.
module digit_serial_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned NDIG = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
  localparam int unsigned CW   = cnt_width(NDIG);

  // Reject configurations that do not split into whole digits.
  generate
    if (DIGIT == 0 || WIDTH == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $fatal(1, "digit_serial_subtractor: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              brw_q, brw_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic [DIGIT-1:0]       dig_diff;
  logic                   dig_bout;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic                   last_dig;

  // One digit slice, reused every RUN cycle on the low digit of the operands.
  sub_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (a_q[DIGIT-1:0]),
    .b    (b_q[DIGIT-1:0]),
    .bin  (brw_q),
    .diff (dig_diff),
    .bout (dig_bout)
  );

  // New digit enters at the top; after NDIG shifts the result is aligned.
  assign res_cat  = {dig_diff, res_q};
  assign last_dig = (cnt_q == CW'(NDIG - 1));

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        res_d = res_cat[WIDTH+DIGIT-1:DIGIT];
        brw_d = dig_bout;
        cnt_d = cnt_q + CW'(1);
        if (last_dig) begin
          state_d = DONE;
`ifdef SUB_SATURATE_EN
          // Clamp underflow to zero; the borrow is still reported.
          if (dig_bout) begin
            res_d = '0;
          end
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      brw_q       <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      brw_q       <= brw_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = res_q;
  assign bout      = brw_q;

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Scoreboard bench for digit_serial_subtractor: a 16-bit/4-bit-digit instance
// (channel 0) and an 8-bit/8-bit-digit instance (channel 1), randomized
// operands, reference computed with plain integer arithmetic.
module tb_digit_serial_subtractor;

  typedef struct {
    logic [15:0] diff;
    logic        bout;
    int          acc;
  } exp_t;

  logic clk;
  logic rst;

  logic        in_valid0, in_ready0, bin0, out_valid0, out_ready0, bout0;
  logic [15:0] a0, b0, diff0;
  logic        in_valid1, in_ready1, bin1, out_valid1, out_ready1, bout1;
  logic [7:0]  a1, b1, diff1;

  int   checks = 0;
  int   errors = 0;
  int   pcyc   = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   hold[2];
  logic prevv[2];
  bit   force_hold0;

  digit_serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .b(b0), .bin(bin0), .out_valid(out_valid0), .out_ready(out_ready0),
    .diff(diff0), .bout(bout0)
  );

  digit_serial_subtractor #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .bin(bin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .diff(diff1), .bout(bout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) pcyc <= pcyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, pcyc);
    end
  endtask

  // Reference: plain signed integer subtraction, wrapped to w bits.
  function automatic exp_t model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                 input logic bi, input int acc);
    longint d;
    exp_t   e;
    d = longint'(av) - longint'(bv) - longint'(bi);
    e.bout = (d < 0);
    if (d < 0) d = d + (longint'(1) << w);
`ifdef SUB_SATURATE_EN
    if (e.bout) d = 0;
`endif
    e.diff = 16'(d);
    e.acc  = acc;
    return e;
  endfunction

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h00FF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic issue(input int ch, input logic [15:0] av, input logic [15:0] bv, input logic bi);
    int          n;
    logic [15:0] m;
    exp_t        e;
    m = (ch == 0) ? 16'hFFFF : 16'h00FF;
    @(negedge clk);
    if (ch == 0) begin
      in_valid0 = 1'b1; a0 = av; b0 = bv; bin0 = bi;
    end else begin
      in_valid1 = 1'b1; a1 = 8'(av); b1 = 8'(bv); bin1 = bi;
    end
    n = 0;
    while (!((ch == 0) ? in_ready0 : in_ready1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk($sformatf("ch%0d_accept_timeout", ch), 0, 1);
    end else begin
      e = model((ch == 0) ? 16 : 8, av & m, bv & m, bi, pcyc + 1);
      if (ch == 0) q0.push_back(e);
      else         q1.push_back(e);
    end
    @(negedge clk);
    if (ch == 0) in_valid0 = 1'b0;
    else         in_valid1 = 1'b0;
  endtask

  // Output monitor: checks latency on the rising out_valid, data every cycle
  // it is held, and applies a random (or forced) out_ready backpressure.
  task automatic mon(input int ch);
    logic        ov, ir, bo, rdy;
    logic [15:0] dv;
    int          nd, sz;
    exp_t        e;
    if (ch == 0) begin
      ov = out_valid0; ir = in_ready0; dv = diff0; bo = bout0; nd = 4; sz = q0.size();
    end else begin
      ov = out_valid1; ir = in_ready1; dv = {8'h00, diff1}; bo = bout1; nd = 1; sz = q1.size();
    end
    rdy = 1'b0;
    if (ov) begin
      if (sz == 0) begin
        chk($sformatf("ch%0d_unexpected_output diff=%h", ch, dv), 1, 0);
        rdy = 1'b1;
      end else begin
        e = (ch == 0) ? q0[0] : q1[0];
        if (!prevv[ch]) begin
          chk($sformatf("ch%0d_latency", ch), longint'(pcyc - e.acc), longint'(nd));
          if (hold[ch] < 0) begin
            hold[ch] = (ch == 0 && force_hold0) ? 5 : int'($urandom_range(0, 2));
            if (ch == 0) force_hold0 = 1'b0;
          end
        end
        chk($sformatf("ch%0d_diff", ch), longint'(dv), longint'(e.diff));
        chk($sformatf("ch%0d_bout", ch), longint'(bo), longint'(e.bout));
        chk($sformatf("ch%0d_in_ready_busy", ch), longint'(ir), 0);
        if (hold[ch] > 0) begin
          hold[ch]--;
        end else begin
          rdy = 1'b1;
          hold[ch] = -1;
          if (ch == 0) void'(q0.pop_front());
          else         void'(q1.pop_front());
        end
      end
    end
    prevv[ch] = ov;
    if (ch == 0) out_ready0 = rdy;
    else         out_ready1 = rdy;
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready0"},  longint'(in_ready0),  1);
    chk({tag, "_out_valid0"}, longint'(out_valid0), 0);
    chk({tag, "_diff0"},      longint'(diff0),      0);
    chk({tag, "_bout0"},      longint'(bout0),      0);
    chk({tag, "_in_ready1"},  longint'(in_ready1),  1);
    chk({tag, "_out_valid1"}, longint'(out_valid1), 0);
    chk({tag, "_diff1"},      longint'(diff1),      0);
    chk({tag, "_bout1"},      longint'(bout1),      0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || out_valid0 || out_valid1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    in_valid0 = 1'b0; a0 = '0; b0 = '0; bin0 = 1'b0; out_ready0 = 1'b0;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0; out_ready1 = 1'b0;
    hold[0] = -1; hold[1] = -1; prevv[0] = 1'b0; prevv[1] = 1'b0;
    force_hold0 = 1'b0;

    repeat (2) @(negedge clk);
    check_reset("por");
    rst = 1'b0;

    // Directed cases.
    issue(0, 16'h1234, 16'h0234, 1'b0);
    issue(0, 16'h0000, 16'h0001, 1'b0);
    issue(0, 16'h8000, 16'h7FFF, 1'b1);
    issue(1, 16'h0010, 16'h0020, 1'b0);
    drain();

    // Backpressure: result held 5 cycles while a stray operand is offered.
    force_hold0 = 1'b1;
    issue(0, 16'hA5A5, 16'h5A5A, 1'b1);
    n = 0;
    while (!out_valid0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("bp_wait_timeout", 0, 1);
    for (int i = 0; i < 4; i++) begin
      in_valid0 = 1'b1; a0 = 16'hFFFF; b0 = 16'h0000; bin0 = 1'b0;
      @(negedge clk);
    end
    in_valid0 = 1'b0;
    drain();

    // Reset in the middle of RUN, after the second digit.
    issue(0, 16'h1111, 16'h0101, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset("mid");
    q0.delete();
    hold[0] = -1;
    prevv[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    issue(0, 16'd5, 16'd3, 1'b0);
    drain();

    // Random operands on both configurations in parallel.
    fork
      begin
        for (int i = 0; i < 1000; i++) issue(0, pick16(), pick16(), 1'($urandom_range(0, 1)));
      end
      begin
        for (int j = 0; j < 1000; j++) issue(1, pick16(), pick16(), 1'($urandom_range(0, 1)));
      end
    join
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
